// File: rtl/mem_access_pkg.sv
// Shared definitions for the byte-serial MEM-stage load/store unit:
// FSM states, access size codes, funct3 load/store values and zero constants.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic [4:0]  ZeroReg  = 5'h0;

  // Number of bytes moved for a funct3 size field; 10 and 11 are both a word.
  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    nbytes = 3'd1;
      SZ_H:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Sign/zero extension of the assembled load word according to funct3.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  op,
  output logic [31:0] data
);

  always_comb begin
    data = ZeroWord;
    case (op)
      F3_LB:   data = {{24{word[7]}}, word[7:0]};
      F3_LH:   data = {{16{word[15]}}, word[15:0]};
      F3_LBU:  data = {24'h0, word[7:0]};
      F3_LHU:  data = {16'h0, word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Byte-serial load/store unit: one request, one RAM byte per cycle, pipeline
// stalled until the DONE cycle, extended load data returned for write-back.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din,
  output logic              stall_o,
  output logic              done_o,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  state_t              state_q, state_d;
  logic                we_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [4:0]          rd_q;
  logic [1:0]          cnt_q;
  logic [31:0]         word_q;
  logic [31:0]         ext_data;
  logic                last;
  logic [1:0]          cap_idx;

  assign last    = (cnt_q == 2'(nbytes(op_q[1:0]) - 3'd1));
  // RAM data lags the address by one cycle, so ACCESS k stores byte k-1.
  assign cap_idx = (state_q == COLLECT) ? cnt_q : cnt_q - 2'd1;

  load_extend u_load_extend (
    .word (word_q),
    .op   (op_q),
    .data (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= ZeroReg;
      cnt_q   <= 2'd0;
      word_q  <= ZeroWord;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            cnt_q   <= 2'd0;
            word_q  <= ZeroWord;
          end
        end
        ACCESS: begin
          if (!we_q && cnt_q != 2'd0) word_q[{cap_idx, 3'b000} +: 8] <= mem_din;
          if (!last) cnt_q <= cnt_q + 2'd1;
        end
        COLLECT: word_q[{cap_idx, 3'b000} +: 8] <= mem_din;
        default: ;
      endcase
    end
  end

  // Next state plus outputs decoded from registered state (stall also sees req_valid).
  always_comb begin
    state_d  = state_q;
    mem_a    = '0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    wb_en    = 1'b0;
    wb_addr  = ZeroReg;
    wb_data  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall_o = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall_o = 1'b1;
        mem_a   = addr_q + ADDR_W'(cnt_q);
        if (we_q) begin
          mem_wr   = 1'b1;
          mem_dout = wdata_q[{cnt_q, 3'b000} +: 8];
        end
        if (last) state_d = we_q ? DONE : COLLECT;
      end
      COLLECT: begin
        stall_o = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
        if (!we_q) begin
          wb_en   = 1'b1;
          wb_addr = rd_q;
          wb_data = DATA_W'(ext_data);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a synchronous byte-wide RAM model.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_wr, stall_o, done_o, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [7:0]  ram [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a = 10'h0;
  logic [7:0]  pre_d = 8'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_total = 0;

  logic [31:0] rec_a    [0:10];
  logic [7:0]  rec_dout [0:10];
  logic        rec_wr   [0:10];
  logic        rec_stall[0:10];
  int          done_cyc;
  logic        r_wb_en;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  int          d0;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .stall_o(stall_o), .done_o(done_o), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    mem_din <= ram[mem_a[9:0]];
  end

  always @(negedge clk) if (done_o) done_total <= done_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Called #1 after a posedge; that clock cycle is request cycle 0.
  task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input bit keep);
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      rec_a[i] = 32'h0; rec_dout[i] = 8'h0; rec_wr[i] = 1'b0; rec_stall[i] = 1'b0;
    end
    done_cyc = 0; r_wb_en = 1'b0; r_wb_addr = 5'h0; r_wb_data = 32'h0;
    #1;
    rec_a[0] = mem_a; rec_dout[0] = mem_dout; rec_wr[0] = mem_wr; rec_stall[0] = stall_o;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      rec_a[c] = mem_a; rec_dout[c] = mem_dout; rec_wr[c] = mem_wr; rec_stall[c] = stall_o;
      if (done_o) begin
        done_cyc = c; r_wb_en = wb_en; r_wb_addr = wb_addr; r_wb_data = wb_data;
        if (!keep) req_valid = 1'b0;
        break;
      end
    end
    if (done_cyc == 0) req_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
    #3;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_wb_en", 32'(wb_en), 32'h0);
    check("rst_wb_addr", 32'(wb_addr), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    #9 rst = 1'b1;
    next_cycle();

    poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
    poke(10'h200, 8'h80); poke(10'h201, 8'hFF);
    poke(10'h302, 8'h77);
    poke(10'h3FE, 8'h11); poke(10'h3FF, 8'h22); poke(10'h000, 8'h33); poke(10'h001, 8'h44);
    poke(10'h180, 8'h00); poke(10'h181, 8'h00); poke(10'h182, 8'h00); poke(10'h183, 8'h00);
    poke(10'h211, 8'h01); poke(10'h212, 8'h02); poke(10'h213, 8'h03);

    // LW 0x100
    d0 = done_total;
    run_req(1'b0, F3_LW, 32'h100, 32'h0, 5'd5, 1'b0);
    check("lw_a_c0", rec_a[0], 32'h0);
    for (int k = 0; k < 4; k++) check($sformatf("lw_a_c%0d", k + 1), rec_a[k + 1], 32'h100 + 32'(k));
    for (int k = 0; k < 6; k++) check($sformatf("lw_stall_c%0d", k), 32'(rec_stall[k]), 32'h1);
    check("lw_wr_c1", 32'(rec_wr[1]), 32'h0);
    check("lw_done_cyc", 32'(done_cyc), 32'd6);
    check("lw_wb_data", r_wb_data, 32'h12345678);
    check("lw_wb_en", 32'(r_wb_en), 32'h1);
    check("lw_wb_addr", 32'(r_wb_addr), 32'd5);
    next_cycle();
    check("lw_stall_after", 32'(stall_o), 32'h0);
    check("lw_one_done", 32'(done_total - d0), 32'd1);

    // Byte and half loads, sign- and zero-extended
    run_req(1'b0, F3_LB, 32'h200, 32'h0, 5'd1, 1'b0);
    check("lb_data", r_wb_data, 32'hFFFFFF80);
    check("lb_done_cyc", 32'(done_cyc), 32'd3);
    next_cycle();
    run_req(1'b0, F3_LBU, 32'h200, 32'h0, 5'd2, 1'b0);
    check("lbu_data", r_wb_data, 32'h00000080);
    check("lbu_done_cyc", 32'(done_cyc), 32'd3);
    next_cycle();
    run_req(1'b0, F3_LH, 32'h200, 32'h0, 5'd3, 1'b0);
    check("lh_data", r_wb_data, 32'hFFFFFF80);
    check("lh_done_cyc", 32'(done_cyc), 32'd4);
    next_cycle();
    run_req(1'b0, F3_LHU, 32'h200, 32'h0, 5'd4, 1'b0);
    check("lhu_data", r_wb_data, 32'h0000FF80);
    next_cycle();
    run_req(1'b0, F3_LH, 32'h102, 32'h0, 5'd6, 1'b0);
    check("lh_pos_data", r_wb_data, 32'h00001234);
    next_cycle();

    // SH 0xABCD1234 to 0x300
    run_req(1'b1, F3_SH, 32'h300, 32'hABCD1234, 5'd7, 1'b0);
    check("sh_a_c1", rec_a[1], 32'h300);
    check("sh_dout_c1", 32'(rec_dout[1]), 32'h34);
    check("sh_wr_c1", 32'(rec_wr[1]), 32'h1);
    check("sh_a_c2", rec_a[2], 32'h301);
    check("sh_dout_c2", 32'(rec_dout[2]), 32'h12);
    check("sh_wr_c2", 32'(rec_wr[2]), 32'h1);
    check("sh_done_cyc", 32'(done_cyc), 32'd3);
    check("sh_wb_en", 32'(r_wb_en), 32'h0);
    check("sh_wr_c3", 32'(rec_wr[3]), 32'h0);
    next_cycle();
    check("sh_ram0", 32'(ram[10'h300]), 32'h34);
    check("sh_ram1", 32'(ram[10'h301]), 32'h12);
    check("sh_ram2", 32'(ram[10'h302]), 32'h77);

    // LW wrapping the top of the address space
    run_req(1'b0, F3_LW, 32'hFFFFFFFE, 32'h0, 5'd8, 1'b0);
    check("wrap_a_c1", rec_a[1], 32'hFFFFFFFE);
    check("wrap_a_c2", rec_a[2], 32'hFFFFFFFF);
    check("wrap_a_c3", rec_a[3], 32'h00000000);
    check("wrap_a_c4", rec_a[4], 32'h00000001);
    check("wrap_data", r_wb_data, 32'h44332211);
    next_cycle();

    // SW aborted by reset during cycle 2
    d0 = done_total;
    req_we = 1'b1; req_op = F3_SW; req_addr = 32'h180; req_wdata = 32'hDEADBEEF;
    req_rd = 5'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    check("swr_dout_c1", 32'(mem_dout), 32'hEF);
    @(posedge clk); #2;
    check("swr_wr_c2", 32'(mem_wr), 32'h1);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check("swr_wr_rst", 32'(mem_wr), 32'h0);
    check("swr_a_rst", mem_a, 32'h0);
    check("swr_stall_rst", 32'(stall_o), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    next_cycle(); next_cycle();
    check("swr_no_done", 32'(done_total - d0), 32'd0);
    check("swr_ram0", 32'(ram[10'h180]), 32'hEF);
    check("swr_ram1", 32'(ram[10'h181]), 32'h00);
    check("swr_ram3", 32'(ram[10'h183]), 32'h00);

    // Back-to-back SB then LW, request held through DONE
    d0 = done_total;
    run_req(1'b1, F3_SB, 32'h210, 32'h0000005A, 5'd0, 1'b1);
    check("b2b_sb_done_cyc", 32'(done_cyc), 32'd2);
    check("b2b_sb_wr_c1", 32'(rec_wr[1]), 32'h1);
    next_cycle();
    run_req(1'b0, F3_LW, 32'h210, 32'h0, 5'd9, 1'b0);
    check("b2b_lw_stall_c0", 32'(rec_stall[0]), 32'h1);
    check("b2b_lw_a_c1", rec_a[1], 32'h210);
    check("b2b_lw_done_cyc", 32'(done_cyc), 32'd6);
    check("b2b_lw_data", r_wb_data, 32'h0302015A);
    check("b2b_lw_rd", 32'(r_wb_addr), 32'd9);
    next_cycle(); next_cycle(); next_cycle();
    check("b2b_done_count", 32'(done_total - d0), 32'd2);
    check("b2b_idle_stall", 32'(stall_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access.md
# mem_access

Byte-serial load/store unit for the MEM stage of the five-stage RV32I core. It accepts one load or store request from the EX/MEM latch and performs it over the 8-bit RAM port one byte per cycle. It holds the pipeline stalled while the access runs. It returns sign- or zero-extended load data together with the register write-back controls.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, register/data width

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  memory request present; held stable while stall_o=1
- req_we  in  1  1=store, 0=load
- req_op  in  3  funct3: [1:0] size (00 byte, 01 half, 10/11 word); [2]=1 zero-extend (loads only)
- req_addr  in  ADDR_W  byte address of the access
- req_wdata  in  DATA_W  store data; low bytes are used
- req_rd  in  5  load destination register
- mem_a  out  ADDR_W  RAM byte address
- mem_dout  out  8  RAM write byte
- mem_wr  out  1  RAM write strobe
- mem_din  in  8  RAM read byte; valid one cycle after mem_a is driven
- stall_o  out  1  holds the IF/ID/EX/MEM latches
- done_o  out  1  one-cycle pulse when the access completes
- wb_en  out  1  register write enable; loads only, valid with done_o
- wb_addr  out  5  write-back register
- wb_data  out  DATA_W  extended load data

## Operation
- N = 1, 2 or 4 bytes, taken from req_op[1:0].
- States:
  - IDLE: waiting for a request.
  - ACCESS: issues byte k, for k = 0..N-1.
  - COLLECT: loads only; captures the final byte.
  - DONE: single-cycle completion state.
- IDLE with req_valid: latch we, op, addr, wdata and rd; set cnt←0; go to ACCESS.
- ACCESS, cycle k:
  - mem_a = addr+k, computed modulo 2^32 so the address wraps.
  - Stores: mem_wr=1 and mem_dout = wdata[8k+7:8k].
  - Loads: mem_wr=0; when k≥1, capture mem_din into byte k-1.
  - After k=N-1: stores go to DONE, loads go to COLLECT.
- COLLECT: capture mem_din into byte N-1, then go to DONE.
- DONE:
  - done_o=1.
  - Loads: wb_en=1 with wb_addr and wb_data.
  - Stores: wb_en=0.
  - Next state is IDLE. A req_valid seen in DONE is not sampled.
- Extension: byte result uses bit 7 and half result uses bit 15, unless req_op[2]=1, which zero-fills.
- Alignment is not checked; any address is legal.
- stall_o = (IDLE & req_valid) | ACCESS | COLLECT. It is 0 in DONE, so the upstream latch advances.
- Outside ACCESS: mem_a=0, mem_dout=0, mem_wr=0.

## Timing
- Reset values: state IDLE; mem_a, mem_dout, mem_wr, stall_o (when req_valid=0), done_o, wb_en, wb_addr and wb_data all 0.
- Reset mid-operation aborts immediately and asynchronously. mem_wr drops the same instant, no done_o is produced, and partially written store bytes remain in RAM.
- Latency is counted from the request cycle (cycle 0) to the done_o cycle:
  - Loads: N+2.
  - Stores: N+1.
  - Examples: LW 6, LH 4, LB 3, SW 5, SB 2.
- Back-to-back requests: the next request is accepted no earlier than the cycle after DONE.
- done_o, wb_* and the mem_* outputs are registered or decoded from registered state only. There is no combinational path from req_* to mem_*.

## Structure
- Shared config include holds:
  - state encodings (IDLE/ACCESS/COLLECT/DONE)
  - size codes SZ_B/SZ_H/SZ_W
  - the funct3 load/store constants
  - ZeroWord / ZeroReg
- One combinational sub-module, load_extend. It takes the assembled 32-bit buffer plus op and returns the extended wb_data.
- The FSM, byte counter and capture buffer stay in mem_access.

## Test plan
- LW at 0x100, RAM holds 78 56 34 12:
  - mem_a = 0x100..0x103 in cycles 1–4.
  - done_o in cycle 6.
  - wb_data=0x12345678, wb_en=1.
  - stall_o=1 in cycles 0–5.
- LB / LBU at 0x200 with byte 0x80: wb_data=0xFFFFFF80 (LB) and 0x00000080 (LBU), done_o in cycle 3.
- SH of 0xABCD1234 to 0x300:
  - Cycle 1: mem_a=0x300, dout=0x34, wr=1.
  - Cycle 2: mem_a=0x301, dout=0x12, wr=1.
  - Cycle 3: done_o=1, wb_en=0.
- LW at 0xFFFFFFFE: mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; bytes assembled in that order.
- SW of 0xDEADBEEF with rst pulled low during cycle 2:
  - mem_wr=0 immediately and state IDLE.
  - No done_o.
  - Only byte 0xEF at the base address is written.
- Back-to-back SB then LW:
  - The second request is accepted in the cycle after DONE.
  - Exactly one done_o pulse per request.
